dice_cgra_cfg_loader: RTL
=========================

// Module: dice_cgra_cfg_loader
// PURPOSE
//  Hardware reader for the CGRA subsystem configuration bitstream. Accepts a word stream (valid/ready)
//  from the config fetch path and assembles predrf_cfg, gprf_cfg, cgra_cfg and cgra_compute_latency.
//  It then raises cfg_valid so the subsystem and dispatcher can start. Replaces file-based config
//  loading with the silicon path that feeds dice_cgra_subsystem.
// PARAMETERS
//  NUM_CGRA_IO        32   IO ports; one pred record and one gprf record per port
//  NUM_TILES          16   CGRA tiles; one cgra record per tile
//  TILE_BITS          156  bits per tile record
//  PRED_BITS          10   bits per predicate-RF port record (2 + 2*IO_PIPE_SEL_WIDTH)
//  GPRF_BITS          51   bits per GPRF port record (2 + 2*IO_PIPE_SEL_WIDTH + 5 + 4*TID_WIDTH)
//  WORD_W             32   stream word width
//  LAT_W              6    width of cgra_compute_latency ($clog2(MAX_CGRA_PIPE_STAGE+1))
// PORTS
//  clk                  in   1                     clock
//  rst_n                in   1                     async active-low reset
//  clr                  in   1                     sync abort; returns to IDLE
//  start                in   1                     pulse: begin a new load
//  in_valid             in   1                     stream word valid
//  in_ready             out  1                     loader accepts word
//  in_data              in   WORD_W                stream word
//  busy                 out  1                     load in progress
//  cfg_valid            out  1                     all sections loaded, outputs stable
//  predrf_cfg           out  PRED_BITS*NUM_CGRA_IO port i at [i*PRED_BITS +: PRED_BITS]
//  gprf_cfg             out  GPRF_BITS*NUM_CGRA_IO port i at [i*GPRF_BITS +: GPRF_BITS]
//  cgra_cfg             out  TILE_BITS*NUM_TILES   tile t at [t*TILE_BITS +: TILE_BITS]
//  cgra_compute_latency out  LAT_W                 pipeline latency word
// BEHAVIOUR
//  Reset: in_ready=0, busy=0, cfg_valid=0, all cfg outputs and latency = 0, state=IDLE.
//  Stream order is fixed: PRED section (NUM_CGRA_IO records), then GPRF section (NUM_CGRA_IO records),
//   then CGRA section (NUM_TILES records), then 1 LAT word.
//  Each record occupies WPR = ceil(BITS/WORD_W) words: PRED=1, GPRF=2, TILE=5 words.
//   Word k of a record carries record bits [k*WORD_W +: WORD_W], LSB-first.
//   Bits beyond BITS in the last word are ignored.
//  Total default load is 32+64+80+1 = 177 words.
//  FSM: IDLE -start-> PRED -> GPRF -> CGRA -> LAT -> DONE.
//   DONE behaves as IDLE with cfg_valid=1; start from DONE re-enters PRED.
//  Counters: word-in-record (wcnt) and record index (rcnt).
//   Transfer = in_valid & in_ready. On the last word of the last record, advance state and clear counters.
//  in_ready=1 exactly in PRED/GPRF/CGRA/LAT. Each transfer writes its slice to the target register
//   in the same cycle; no skid buffer, zero bubbles, 1 word/cycle sustained.
//  LAT: cgra_compute_latency <= in_data[LAT_W-1:0]. Next cycle: state=DONE, cfg_valid=1, busy=0.
//  busy=1 in PRED..LAT. cfg_valid drops the cycle after start is accepted and stays low until DONE.
//  start while busy: ignored. start and clr in the same cycle: clr wins.
//  clr: state->IDLE, counters->0, cfg_valid->0. Cfg registers keep partial contents (not cleared).
//  Async reset mid-load: full reset values; the stream source must restart from word 0.
//  in_valid outside load states: no effect, word not consumed.
// STRUCTURE
//  Package dice_cfg_pkg: state enum cfg_ld_state_e {IDLE,PRED,GPRF,CGRA,LAT,DONE}; IO_PIPE_SEL_WIDTH,
//   TID_WIDTH, PRED_BITS/GPRF_BITS/TILE_BITS constants; function words_per_rec(bits).
//  Single module, no submodule. Slice writes use a generate over record index, gated by
//   (state, rcnt, wcnt) decode. Last word of a record is masked to the remaining BITS - k*WORD_W bits.
// TESTING
//  1 Reset: after rst_n release, all outputs 0, in_ready=0. 177 valid words with no start -> nothing consumed.
//  2 Full load: start, 177 words, in_data = word index.
//    Expect: predrf_cfg[9:0]=0; gprf port0 = {word33[18:0],word32}; tile0 = {word100[27:0],words 99..96};
//    latency=176[5:0]=6'd48; cfg_valid=1 exactly 1 cycle after the LAT transfer.
//  3 Backpressure: random in_valid gaps (50%) -> same result as test 2, busy held throughout.
//  4 Ignored bits: last GPRF word = 32'hFFFF_FFFF -> only 19 bits land; the neighbour port's bits are unchanged.
//  5 clr after 40 words -> IDLE, cfg_valid=0. New start + 177 words -> result identical to test 2.
//  6 start at word 10 of a load is ignored. After DONE, a second start drops cfg_valid; reloading all-ones
//    words -> every cfg bit =1, latency=6'h3F.

Source files
------------

// File: rtl/dice_cgra_cfg_loader_pkg.sv
// Shared types and record geometry for the CGRA configuration bitstream loader.
// Record widths are derived from the IO pipe-select and thread-id field widths.
package dice_cfg_pkg;

  localparam int WORD_W            = 32;
  localparam int IO_PIPE_SEL_WIDTH = 4;
  localparam int TID_WIDTH         = 9;

  localparam int PRED_BITS = 2 + 2*IO_PIPE_SEL_WIDTH;
  localparam int GPRF_BITS = 2 + 2*IO_PIPE_SEL_WIDTH + 5 + 4*TID_WIDTH;
  localparam int TILE_BITS = 156;

  typedef enum logic [2:0] {
    IDLE,
    PRED,
    GPRF,
    CGRA,
    LAT,
    DONE
  } cfg_ld_state_e;

  function automatic int words_per_rec(input int bits);
    return (bits + WORD_W - 1) / WORD_W;
  endfunction

  // Width of word k of a record; the final word only carries the leftover bits.
  function automatic int slice_width(input int bits, input int k);
    int rem;
    rem = bits - k*WORD_W;
    return (rem < WORD_W) ? rem : WORD_W;
  endfunction

endpackage

// File: rtl/dice_cgra_cfg_loader_if.sv
// Valid/ready word stream from the config fetch path into the loader.
// The fetch side drives the master modport, the loader consumes through slave.
interface dice_cgra_cfg_loader_if #(
  parameter int WORD_W = dice_cfg_pkg::WORD_W
);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/dice_cgra_cfg_loader.sv
// Assembles predicate-RF, GPRF and tile configuration plus the compute latency
// from a fixed-order word stream, then raises cfg_valid for the CGRA subsystem.
module dice_cgra_cfg_loader
  import dice_cfg_pkg::*;
#(
  parameter int NUM_CGRA_IO = 32,
  parameter int NUM_TILES   = 16,
  parameter int LAT_W       = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           start,
  dice_cgra_cfg_loader_if.slave          cfg_in,
  output logic                           busy,
  output logic                           cfg_valid,
  output logic [PRED_BITS*NUM_CGRA_IO-1:0] predrf_cfg,
  output logic [GPRF_BITS*NUM_CGRA_IO-1:0] gprf_cfg,
  output logic [TILE_BITS*NUM_TILES-1:0]   cgra_cfg,
  output logic [LAT_W-1:0]               cgra_compute_latency
);

  localparam int PRED_WPR = words_per_rec(PRED_BITS);
  localparam int GPRF_WPR = words_per_rec(GPRF_BITS);
  localparam int TILE_WPR = words_per_rec(TILE_BITS);

  localparam int MAX_REC  = (NUM_CGRA_IO > NUM_TILES) ? NUM_CGRA_IO : NUM_TILES;
  localparam int MAX_WPR0 = (PRED_WPR > GPRF_WPR) ? PRED_WPR : GPRF_WPR;
  localparam int MAX_WPR  = (MAX_WPR0 > TILE_WPR) ? MAX_WPR0 : TILE_WPR;
  localparam int RCNT_W   = (MAX_REC > 1) ? $clog2(MAX_REC) : 1;
  localparam int WCNT_W   = (MAX_WPR > 1) ? $clog2(MAX_WPR) : 1;

  localparam int PRED_W = PRED_BITS*NUM_CGRA_IO;
  localparam int GPRF_W = GPRF_BITS*NUM_CGRA_IO;
  localparam int CGRA_W = TILE_BITS*NUM_TILES;

  cfg_ld_state_e     state_q, state_d;
  cfg_ld_state_e     next_sec;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d, last_wcnt;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d, last_rcnt;
  logic              cfg_valid_q, cfg_valid_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [PRED_W-1:0] predrf_q, predrf_d;
  logic [GPRF_W-1:0] gprf_q, gprf_d;
  logic [CGRA_W-1:0] cgra_q, cgra_d;

  logic              loading;
  logic              xfer;
  logic [WORD_W-1:0] in_data;

  assign in_data         = cfg_in.in_data;
  assign loading         = (state_q == PRED) || (state_q == GPRF) ||
                           (state_q == CGRA) || (state_q == LAT);
  assign xfer            = cfg_in.in_valid && loading;
  assign cfg_in.in_ready = loading;
  assign busy            = loading;

  assign cfg_valid            = cfg_valid_q;
  assign predrf_cfg           = predrf_q;
  assign gprf_cfg             = gprf_q;
  assign cgra_cfg             = cgra_q;
  assign cgra_compute_latency = lat_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    cfg_valid_d = cfg_valid_q;
    lat_d       = lat_q;
    last_wcnt   = '0;
    last_rcnt   = '0;
    next_sec    = DONE;

    case (state_q)
      PRED: begin
        last_wcnt = WCNT_W'(PRED_WPR - 1);
        last_rcnt = RCNT_W'(NUM_CGRA_IO - 1);
        next_sec  = GPRF;
      end
      GPRF: begin
        last_wcnt = WCNT_W'(GPRF_WPR - 1);
        last_rcnt = RCNT_W'(NUM_CGRA_IO - 1);
        next_sec  = CGRA;
      end
      CGRA: begin
        last_wcnt = WCNT_W'(TILE_WPR - 1);
        last_rcnt = RCNT_W'(NUM_TILES - 1);
        next_sec  = LAT;
      end
      default: begin
        last_wcnt = '0;
        last_rcnt = '0;
        next_sec  = DONE;
      end
    endcase

    // clr outranks start and any in-flight transfer; cfg registers keep partial data.
    if (clr) begin
      state_d     = IDLE;
      wcnt_d      = '0;
      rcnt_d      = '0;
      cfg_valid_d = 1'b0;
    end else if (!loading) begin
      if (start) begin
        state_d     = PRED;
        wcnt_d      = '0;
        rcnt_d      = '0;
        cfg_valid_d = 1'b0;
      end
    end else if (xfer) begin
      if (state_q == LAT) begin
        lat_d = in_data[LAT_W-1:0];
      end
      if (wcnt_q != last_wcnt) begin
        wcnt_d = wcnt_q + 1'b1;
      end else begin
        wcnt_d = '0;
        if (rcnt_q != last_rcnt) begin
          rcnt_d = rcnt_q + 1'b1;
        end else begin
          rcnt_d  = '0;
          state_d = next_sec;
          if (next_sec == DONE) begin
            cfg_valid_d = 1'b1;
          end
        end
      end
    end
  end

  // Per-port slice writers: each word lands directly in its record bits.
  for (genvar i = 0; i < NUM_CGRA_IO; i++) begin : g_io
    for (genvar k = 0; k < PRED_WPR; k++) begin : g_pred
      localparam int W = slice_width(PRED_BITS, k);
      localparam int B = i*PRED_BITS + k*WORD_W;
      logic we;
      assign we = xfer && (state_q == PRED) &&
                  (rcnt_q == RCNT_W'(i)) && (wcnt_q == WCNT_W'(k));
      assign predrf_d[B +: W] = we ? in_data[W-1:0] : predrf_q[B +: W];
    end
    for (genvar k = 0; k < GPRF_WPR; k++) begin : g_gprf
      localparam int W = slice_width(GPRF_BITS, k);
      localparam int B = i*GPRF_BITS + k*WORD_W;
      logic we;
      assign we = xfer && (state_q == GPRF) &&
                  (rcnt_q == RCNT_W'(i)) && (wcnt_q == WCNT_W'(k));
      assign gprf_d[B +: W] = we ? in_data[W-1:0] : gprf_q[B +: W];
    end
  end

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    for (genvar k = 0; k < TILE_WPR; k++) begin : g_word
      localparam int W = slice_width(TILE_BITS, k);
      localparam int B = t*TILE_BITS + k*WORD_W;
      logic we;
      assign we = xfer && (state_q == CGRA) &&
                  (rcnt_q == RCNT_W'(t)) && (wcnt_q == WCNT_W'(k));
      assign cgra_d[B +: W] = we ? in_data[W-1:0] : cgra_q[B +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      cfg_valid_q <= 1'b0;
      lat_q       <= '0;
      predrf_q    <= '0;
      gprf_q      <= '0;
      cgra_q      <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      cfg_valid_q <= cfg_valid_d;
      lat_q       <= lat_d;
      predrf_q    <= predrf_d;
      gprf_q      <= gprf_d;
      cgra_q      <= cgra_d;
    end
  end

endmodule
